// File: rtl/mem_access_ctrl_pkg.sv
// slc3_mem_pkg: shared types and constants for the SLC-3 SRAM sequencer.
// Holds state encoding, the I/O-mapped address and default wait states.
package slc3_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ACT,
    RD_DONE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    IO_DONE
  } mem_state_t;

  localparam logic [15:0] IO_ADDR = 16'hFFFF;
  localparam int RD_WAIT_DEF = 2;
  localparam int WR_PULSE_DEF = 3;
  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: control-unit side request/response bundle.
// master = SLC-3 control unit, slave = memory access sequencer.
interface mem_access_ctrl_if;

  logic        Req_Rd;
  logic        Req_Wr;
  logic [15:0] Addr;
  logic [15:0] Wr_data;
  logic [15:0] Rd_data;
  logic        Ready;
  logic        Busy;

  modport master (
    output Req_Rd, Req_Wr, Addr, Wr_data,
    input  Rd_data, Ready, Busy
  );

  modport slave (
    input  Req_Rd, Req_Wr, Addr, Wr_data,
    output Rd_data, Ready, Busy
  );

endinterface

// File: rtl/mem_access_ctrl_wait_counter.sv
// wait_counter: 4-bit loadable down-counter with a done flag.
// done is high on the final counted cycle (count of one or less).
module wait_counter
  import slc3_mem_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = cnt <= CNT_W'(1);

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: SLC-3 to async SRAM access sequencer, registered strobes.
// Define MEM_IO_MAP_EN to map address 16'hFFFF onto Switches/Hex_data.
module mem_access_ctrl #(
  parameter int ADDR_W   = 20,
  parameter int RD_WAIT  = slc3_mem_pkg::RD_WAIT_DEF,
  parameter int WR_PULSE = slc3_mem_pkg::WR_PULSE_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  mem_access_ctrl_if.slave  cu,
  output logic [ADDR_W-1:0] Sram_addr,
  input  logic [15:0]       Sram_dq_in,
  output logic [15:0]       Sram_dq_out,
  output logic              Sram_dq_oe,
`ifdef MEM_IO_MAP_EN
  input  logic [15:0]       Switches,
  output logic [15:0]       Hex_data,
`endif
  output logic              CE_N,
  output logic              UB_N,
  output logic              LB_N,
  output logic              OE_N,
  output logic              WE_N
);

  import slc3_mem_pkg::mem_state_t;
  import slc3_mem_pkg::IDLE;
  import slc3_mem_pkg::RD_ACT;
  import slc3_mem_pkg::RD_DONE;
  import slc3_mem_pkg::WR_SETUP;
  import slc3_mem_pkg::WR_HOLD;
  import slc3_mem_pkg::IO_DONE;
  import slc3_mem_pkg::CNT_W;

  mem_state_t state, state_nx;
  logic start, start_wr, io_hit;
  logic cnt_load, cnt_en, cnt_done;
  logic [CNT_W-1:0] cnt_val;
  logic sel_ce;

`ifdef MEM_IO_MAP_EN
  logic io_wr;
  assign io_hit = cu.Addr == slc3_mem_pkg::IO_ADDR;
`else
  assign io_hit = 1'b0;
`endif

  // Write has priority when both requests arrive together.
  assign start    = state == IDLE && (cu.Req_Rd || cu.Req_Wr);
  assign start_wr = cu.Req_Wr;
  assign cnt_load = (start && !start_wr && !io_hit) || state == WR_SETUP;
  assign cnt_val  = state == IDLE ? CNT_W'(RD_WAIT) : CNT_W'(WR_PULSE);
  assign cnt_en   = state == RD_ACT || state == slc3_mem_pkg::WR_PULSE;
  assign cu.Busy  = state != IDLE;

  wait_counter u_wait (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .done     (cnt_done)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (start)
          state_nx = io_hit   ? IO_DONE
                   : start_wr ? WR_SETUP : RD_ACT;
      RD_ACT:   if (cnt_done) state_nx = RD_DONE;
      RD_DONE:  state_nx = IDLE;
      WR_SETUP: state_nx = slc3_mem_pkg::WR_PULSE;
      slc3_mem_pkg::WR_PULSE:
        if (cnt_done) state_nx = WR_HOLD;
      WR_HOLD:  state_nx = IDLE;
      IO_DONE:  state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Pads are a registered decode of the state: address leads strobes by a cycle.
  assign sel_ce = state == RD_ACT || state == WR_SETUP ||
                  state == slc3_mem_pkg::WR_PULSE || state == WR_HOLD;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      CE_N       <= 1'b1;
      UB_N       <= 1'b1;
      LB_N       <= 1'b1;
      OE_N       <= 1'b1;
      WE_N       <= 1'b1;
      Sram_dq_oe <= 1'b0;
      cu.Ready   <= 1'b0;
    end else begin
      CE_N       <= !sel_ce;
      UB_N       <= !sel_ce;
      LB_N       <= !sel_ce;
      OE_N       <= state != RD_ACT;
      WE_N       <= state != slc3_mem_pkg::WR_PULSE;
      Sram_dq_oe <= state == WR_SETUP || state == WR_HOLD ||
                    state == slc3_mem_pkg::WR_PULSE;
      cu.Ready   <= state == RD_DONE || state == WR_HOLD ||
                    state == IO_DONE;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Sram_addr   <= '0;
      Sram_dq_out <= '0;
      cu.Rd_data  <= '0;
`ifdef MEM_IO_MAP_EN
      io_wr       <= 1'b0;
      Hex_data    <= '0;
`endif
    end else begin
      if (start && !io_hit) Sram_addr <= ADDR_W'(cu.Addr);
      if (start && start_wr) Sram_dq_out <= cu.Wr_data;
      if (state == RD_DONE) cu.Rd_data <= Sram_dq_in;
`ifdef MEM_IO_MAP_EN
      if (start) io_wr <= start_wr;
      if (state == IO_DONE) begin
        if (io_wr) Hex_data   <= Sram_dq_out;
        else       cu.Rd_data <= Switches;
      end
`endif
    end
  end

endmodule
